ave_filter_mc: RTL and testbench
================================

Name: ave_filter_mc

Overview:
- Multi-channel block averager: successor to the single-channel fixed-256 block averager.
- Accepts time-interleaved samples tagged with a channel index.
- Keeps an independent accumulator and counter per channel; emits one average per channel per block of 2^L samples.
- L is runtime-selectable. Sits between the channelised power-detector output and the FRB threshold/trigger logic.

Parameters:
- DATA_WIDTH, 16, sample and average width.
- NUM_CH, 4, number of interleaved channels (1..64).
- MAX_LOG2, 10, largest supported log2 block length; accumulator width = DATA_WIDTH + MAX_LOG2.
- SIGNED, 0, 1 = two's-complement samples with arithmetic shift; 0 = unsigned.

Ports:
- clk_data, input, 1, data clock; all logic is on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous clear of all channel accumulators and counters.
- ave_log2, input, clog2(MAX_LOG2+1), requested log2 block length; 0 = pass-through.
- data_in, input, DATA_WIDTH, sample.
- data_in_ch, input, CH_W (= max(1, clog2(NUM_CH))), channel index of data_in.
- data_in_valid, input, 1, sample qualifier.
- data_out, output, DATA_WIDTH, block average.
- data_out_ch, output, CH_W, channel of data_out.
- data_out_valid, output, 1, one-cycle pulse qualifying data_out and data_out_ch.
- ch_err, output, 1, one-cycle pulse when a sample with data_in_ch >= NUM_CH is received.

Behaviour:
- Reset: all outputs are 0. All accumulators, counters and per-channel latched lengths are 0.
- Per-channel state:
  - acc[c], DATA_WIDTH+MAX_LOG2 bits.
  - cnt[c], MAX_LOG2 bits.
  - len[c], the latched log2 length.
- Length latch:
  - When a valid sample for channel c arrives with cnt[c]==0, len[c] takes min(ave_log2, MAX_LOG2).
  - Changes to ave_log2 mid-block do not affect that block; they take effect at the next block boundary of each channel.
- Accepted sample (data_in_valid=1, clear=0, data_in_ch<NUM_CH), with L = the effective len[c]:
  - If cnt[c] < 2^L - 1: acc[c] <= acc[c] + ext(data_in) and cnt[c] <= cnt[c] + 1.
  - Else (last sample of the block):
    - data_out <= (acc[c] + ext(data_in)) >> L, truncated to DATA_WIDTH.
    - data_out_ch <= c; data_out_valid <= 1.
    - acc[c] <= 0; cnt[c] <= 0.
  - ext() is sign extension if SIGNED=1, otherwise zero extension.
  - The shift is arithmetic if SIGNED=1.
  - All 2^L samples are included in the sum; none is dropped at the boundary.
- L = 0 (pass-through): every accepted sample produces data_out = data_in one cycle later.
- Latency: data_out_valid is asserted exactly one cycle after the accepting edge of the last sample. The output is registered; no combinational path runs from data_in to the outputs.
- data_out and data_out_ch hold their last value while data_out_valid=0.
- Back-to-back: a valid sample on every cycle, on any channel sequence, is supported. Consecutive completions on different channels produce consecutive output pulses.
- Out-of-range channel (data_in_ch >= NUM_CH): the sample is discarded, no state changes, and ch_err pulses the next cycle.
- clear=1:
  - All acc, cnt and len are zeroed.
  - Any sample on the same cycle is discarded.
  - No data_out_valid pulse is generated from that sample. A pulse already registered from the previous cycle still appears.
- Overflow cannot occur: acc width covers 2^MAX_LOG2 full-scale samples.
- Reset mid-block: asynchronous and immediate. Partial sums are lost and outputs return to 0.

Optional Feature:
- Macro AVE_FILTER_MC_ROUND_EN.
- When defined, and only for L>0, the output adds 2^(L-1) before the shift, i.e. data_out = (acc + ext(data_in) + 2^(L-1)) >> L.
  - This is round-half-up; for SIGNED it rounds toward +inf at ties.
  - The extra addition is done at accumulator width + 1 and must not overflow.
- When undefined, the output is truncated (floor, by arithmetic shift).
- Latency is the same in both builds.

Test Plan:
- NUM_CH=1, ave_log2=2, samples 1,2,3,4 on back-to-back cycles -> one pulse, data_out=2 (floor of 2.5); with ROUND_EN, data_out=3. The pulse comes one cycle after sample 4.
- NUM_CH=4, ave_log2=3, round-robin ch0..3, ch c carrying constant 100*(c+1) for 32 cycles -> four pulses on consecutive cycles: ch0=100, ch1=200, ch2=300, ch3=400.
- ave_log2 changed from 2 to 0 after the 2nd sample of a ch0 block -> the current block still averages 4 samples; thereafter every ch0 sample echoes with a 1-cycle latency.
- SIGNED=1, ave_log2=1, samples -3 and -4 -> data_out=-4 (0xFFFC); with ROUND_EN, data_out=-3 (0xFFFD).
- clear asserted together with the 4th sample of a ave_log2=2 block -> no pulse. The next 4 samples 8,8,8,8 -> data_out=8.
- data_in_ch=NUM_CH with valid -> ch_err pulses for one cycle, no output, and the accumulators are unchanged. Deassert rst_n mid-block -> all outputs 0 immediately, and the following block averages correctly.

Source files
------------

// File: rtl/ave_filter_mc.sv
// Multi-channel block averager, 2^L samples per channel; AVE_FILTER_MC_ROUND_EN selects round-half-up instead of floor.
// Average registered one cycle after the last sample; no backpressure, a sample may arrive every cycle.
module ave_filter_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int MAX_LOG2   = 10,
  parameter int SIGNED     = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LW        = $clog2(MAX_LOG2 + 1)
) (
  input  logic                  clk_data,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [LW-1:0]         ave_log2,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CH_W-1:0]       data_in_ch,
  input  logic                  data_in_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CH_W-1:0]       data_out_ch,
  output logic                  data_out_valid,
  output logic                  ch_err
);

  localparam int AW = DATA_WIDTH + MAX_LOG2;
  localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);
  localparam logic [LW-1:0]   MAX_LEN  = LW'(MAX_LOG2);

  logic [AW-1:0]       acc [NUM_CH];
  logic [MAX_LOG2-1:0] cnt [NUM_CH];
  logic [LW-1:0]       len [NUM_CH];

  logic                  in_range, accept, last;
  logic [CH_W-1:0]       ch_idx;
  logic [LW-1:0]         req_len, eff_len;
  logic [MAX_LOG2-1:0]   blk_last;
  logic [AW:0]           acc_x, din_x, sum_acc, rnd, sum_out;
  logic [DATA_WIDTH-1:0] avg;

  always_comb begin
    in_range = {1'b0, data_in_ch} < NUM_CH_V;
    accept   = data_in_valid && !clear && in_range;
    ch_idx   = in_range ? data_in_ch : '0;
    req_len  = (ave_log2 > MAX_LEN) ? MAX_LEN : ave_log2;
    // A new block latches the requested length; mid-block the latched one rules.
    eff_len  = (cnt[ch_idx] == '0) ? req_len : len[ch_idx];
    // At eff_len == MAX_LOG2 the shift wraps to zero, giving all-ones as intended.
    blk_last = (MAX_LOG2'(1) << eff_len) - MAX_LOG2'(1);
    last     = (cnt[ch_idx] == blk_last);
    if (SIGNED != 0) begin
      acc_x = {acc[ch_idx][AW-1], acc[ch_idx]};
      din_x = {{(MAX_LOG2 + 1){data_in[DATA_WIDTH-1]}}, data_in};
    end else begin
      acc_x = {1'b0, acc[ch_idx]};
      din_x = {{(MAX_LOG2 + 1){1'b0}}, data_in};
    end
    sum_acc = acc_x + din_x;
    rnd     = '0;
`ifdef AVE_FILTER_MC_ROUND_EN
    if (eff_len != '0) rnd = (AW + 1)'(1) << (eff_len - LW'(1));
`endif
    sum_out = sum_acc + rnd;
    if (SIGNED != 0) avg = DATA_WIDTH'($signed(sum_out) >>> eff_len);
    else             avg = DATA_WIDTH'(sum_out >> eff_len);
  end

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      data_out       <= '0;
      data_out_ch    <= '0;
      data_out_valid <= 1'b0;
      ch_err         <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
        len[i] <= '0;
      end
    end else begin
      data_out_valid <= 1'b0;
      ch_err         <= data_in_valid && !clear && !in_range;
      if (clear) begin
        for (int i = 0; i < NUM_CH; i++) begin
          acc[i] <= '0;
          cnt[i] <= '0;
          len[i] <= '0;
        end
      end else if (accept) begin
        len[ch_idx] <= eff_len;
        if (last) begin
          data_out       <= avg;
          data_out_ch    <= ch_idx;
          data_out_valid <= 1'b1;
          acc[ch_idx]    <= '0;
          cnt[ch_idx]    <= '0;
        end else begin
          acc[ch_idx] <= sum_acc[AW-1:0];
          cnt[ch_idx] <= cnt[ch_idx] + MAX_LOG2'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ave_filter_mc.sv
// Directed bench for ave_filter_mc: unsigned 4-channel and signed 3-channel instances share one stimulus stream.
module tb_ave_filter_mc;

  logic        clk_data = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [3:0]  ave_log2;
  logic [15:0] data_in;
  logic [1:0]  data_in_ch;
  logic        data_in_valid;

  logic [15:0] u_out, s_out;
  logic [1:0]  u_ch, s_ch;
  logic        u_vld, s_vld, u_err, s_err;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk_data = ~clk_data;

  ave_filter_mc #(.DATA_WIDTH(16), .NUM_CH(4), .MAX_LOG2(10), .SIGNED(0)) u_dut (
    .clk_data(clk_data), .rst_n(rst_n), .clear(clear), .ave_log2(ave_log2),
    .data_in(data_in), .data_in_ch(data_in_ch), .data_in_valid(data_in_valid),
    .data_out(u_out), .data_out_ch(u_ch), .data_out_valid(u_vld), .ch_err(u_err)
  );

  ave_filter_mc #(.DATA_WIDTH(16), .NUM_CH(3), .MAX_LOG2(10), .SIGNED(1)) s_dut (
    .clk_data(clk_data), .rst_n(rst_n), .clear(clear), .ave_log2(ave_log2),
    .data_in(data_in), .data_in_ch(data_in_ch), .data_in_valid(data_in_valid),
    .data_out(s_out), .data_out_ch(s_ch), .data_out_valid(s_vld), .ch_err(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_data);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [15:0] d);
    data_in_valid = v;
    data_in_ch    = ch;
    data_in       = d;
  endtask

  initial begin
    logic [15:0] exp_t1, exp_sg;
`ifdef AVE_FILTER_MC_ROUND_EN
    exp_t1 = 16'd3;
    exp_sg = 16'hFFFD;
`else
    exp_t1 = 16'd2;
    exp_sg = 16'hFFFC;
`endif
    rst_n = 1'b0; clear = 1'b0; ave_log2 = 4'd0;
    drive(1'b0, 2'd0, 16'd0);
    tick(); tick();
    chk("rst_out",  {16'd0, u_out}, 32'd0);
    chk("rst_ch",   {30'd0, u_ch},  32'd0);
    chk("rst_vld",  {31'd0, u_vld}, 32'd0);
    chk("rst_err",  {31'd0, u_err}, 32'd0);
    chk("rst_svld", {31'd0, s_vld}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1,2,3,4 on ch0 with L=2
    ave_log2 = 4'd2;
    drive(1'b1, 2'd0, 16'd1); tick();
    drive(1'b1, 2'd0, 16'd2); tick();
    drive(1'b1, 2'd0, 16'd3); tick();
    chk("t1_novld", {31'd0, u_vld}, 32'd0);
    drive(1'b1, 2'd0, 16'd4); tick();
    chk("t1_vld", {31'd0, u_vld}, 32'd1);
    chk("t1_out", {16'd0, u_out}, {16'd0, exp_t1});
    chk("t1_ch",  {30'd0, u_ch},  32'd0);
    drive(1'b0, 2'd0, 16'd0); tick();
    chk("t1_pulse_end", {31'd0, u_vld}, 32'd0);
    chk("t1_hold", {16'd0, u_out}, {16'd0, exp_t1});

    // round-robin, L=3, ch c carries 100*(c+1)
    ave_log2 = 4'd3;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 2'(i % 4), 16'(100 * ((i % 4) + 1)));
      tick();
      if (i == 27) chk("t2_early", {31'd0, u_vld}, 32'd0);
      if (i >= 28) begin
        chk("t2_vld", {31'd0, u_vld}, 32'd1);
        chk("t2_out", {16'd0, u_out}, 32'(100 * (i - 27)));
        chk("t2_ch",  {30'd0, u_ch},  32'(i - 28));
      end
    end
    drive(1'b0, 2'd0, 16'd0); tick();

    // length change mid-block takes effect at the next boundary
    ave_log2 = 4'd2;
    drive(1'b1, 2'd0, 16'd10); tick();
    drive(1'b1, 2'd0, 16'd20); tick();
    ave_log2 = 4'd0;
    drive(1'b1, 2'd0, 16'd30); tick();
    chk("t3_mid", {31'd0, u_vld}, 32'd0);
    drive(1'b1, 2'd0, 16'd40); tick();
    chk("t3_vld", {31'd0, u_vld}, 32'd1);
    chk("t3_out", {16'd0, u_out}, 32'd25);
    drive(1'b1, 2'd0, 16'd7); tick();
    chk("t3_pt1_vld", {31'd0, u_vld}, 32'd1);
    chk("t3_pt1", {16'd0, u_out}, 32'd7);
    drive(1'b1, 2'd0, 16'd9); tick();
    chk("t3_pt2", {16'd0, u_out}, 32'd9);
    drive(1'b0, 2'd0, 16'd0); tick();

    // signed: -3, -4 with L=1
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    ave_log2 = 4'd1;
    drive(1'b1, 2'd0, 16'hFFFD); tick();
    drive(1'b1, 2'd0, 16'hFFFC); tick();
    chk("t4_vld", {31'd0, s_vld}, 32'd1);
    chk("t4_out", {16'd0, s_out}, {16'd0, exp_sg});
    drive(1'b0, 2'd0, 16'd0); tick();

    // clear with the 4th sample drops the block
    ave_log2 = 4'd2;
    drive(1'b1, 2'd0, 16'd1); tick();
    drive(1'b1, 2'd0, 16'd1); tick();
    drive(1'b1, 2'd0, 16'd1); tick();
    clear = 1'b1;
    drive(1'b1, 2'd0, 16'd1); tick();
    clear = 1'b0;
    chk("t5_clr_novld", {31'd0, u_vld}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd0, 16'd8); tick();
      if (i < 3) chk("t5_partial", {31'd0, u_vld}, 32'd0);
    end
    chk("t5_vld", {31'd0, u_vld}, 32'd1);
    chk("t5_out", {16'd0, u_out}, 32'd8);
    drive(1'b0, 2'd0, 16'd0); tick();

    // out-of-range channel on the 3-channel instance
    ave_log2 = 4'd1;
    drive(1'b1, 2'd0, 16'd16); tick();
    drive(1'b1, 2'd3, 16'd1000); tick();
    chk("t6_err", {31'd0, s_err}, 32'd1);
    chk("t6_novld", {31'd0, s_vld}, 32'd0);
    drive(1'b1, 2'd0, 16'd20); tick();
    chk("t6_err_end", {31'd0, s_err}, 32'd0);
    chk("t6_vld", {31'd0, s_vld}, 32'd1);
    chk("t6_out", {16'd0, s_out}, 32'd18);
    drive(1'b0, 2'd0, 16'd0); tick();

    // asynchronous reset mid-block
    ave_log2 = 4'd2;
    drive(1'b1, 2'd1, 16'd5); tick();
    drive(1'b1, 2'd1, 16'd5); tick();
    drive(1'b0, 2'd0, 16'd0);
    chk("t7_pre_out", {16'd0, u_out}, 32'd18);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_out", {16'd0, u_out}, 32'd0);
    chk("t7_rst_sout", {16'd0, s_out}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 2'd1, 16'd4);  tick();
    drive(1'b1, 2'd1, 16'd8);  tick();
    drive(1'b1, 2'd1, 16'd12); tick();
    chk("t7_partial", {31'd0, u_vld}, 32'd0);
    drive(1'b1, 2'd1, 16'd16); tick();
    chk("t7_vld", {31'd0, u_vld}, 32'd1);
    chk("t7_out", {16'd0, u_out}, 32'd10);
    chk("t7_ch",  {30'd0, u_ch},  32'd1);
    drive(1'b0, 2'd0, 16'd0); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
